read_data_sink: RTL and testbench
=================================

Name: read_data_sink

Overview:
- Downstream stage of the HBM read-address issuer. Consumes the HBM AXI read-data (R) channel and buffers the beats in a small show-ahead FIFO.
- Presents the buffered beats as a valid/ready stream to the consuming logic.
- Frames beats into bursts by counting, checks RLAST, RRESP and RID per beat, and raises rd_done once the full read sequence has been received and drained.

Parameters:
- DATA_W, 128: AXI RDATA and output data width.
- ID_W, 4: AXI RID width.
- BURST_LEN, 100: beats per burst (matches ARLEN 0x63).
- NUM_BURSTS, 5: bursts expected per sequence.
- EXP_ID, 0: expected RID value.
- FIFO_DEPTH, 16: buffer entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- init_done  in  1  enable; low acts as a synchronous clear.
- AXI_RDATA  in  DATA_W  read data.
- AXI_RID  in  ID_W  read ID.
- AXI_RLAST  in  1  last beat of burst.
- AXI_RRESP  in  2  read response.
- AXI_RVALID  in  1  beat valid.
- AXI_RREADY  out  1  beat accept.
- m_data  out  DATA_W  head-of-FIFO data.
- m_last  out  1  head beat is the counted last beat of its burst.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer pops the head beat.
- burst_cnt  out  $clog2(NUM_BURSTS+1)  bursts fully received.
- beat_cnt  out  $clog2(BURST_LEN)  beat index within the current burst.
- err_last  out  1  sticky RLAST framing error.
- err_resp  out  1  sticky non-OKAY response error.
- err_id  out  1  sticky RID mismatch.
- rd_done  out  1  sequence complete.

Behaviour:
- Interface: one clock. Reset is asynchronous and active-low (sys_rst_n); the ports are named clk and sys_rst_n.
- Reset values: every output is 0 (AXI_RREADY=0, m_valid=0, rd_done=0, all counters and errors 0), FIFO empty, state IDLE.
- State machine:
  - IDLE: entered on reset or when init_done=0. Go to RUN when init_done=1.
  - RUN: accepting beats. Go to DRAIN on acceptance of the final beat, i.e. the BURST_LEN-th beat of burst NUM_BURSTS.
  - DRAIN: FIFO emptying, AXI_RREADY=0. Go to DONE when the FIFO is empty.
  - DONE: rd_done=1, AXI_RREADY=0. Hold until init_done=0.
- init_done=0 in any state: next edge goes to IDLE; flush the FIFO and clear the counters, errors and rd_done (synchronous clear).
- AXI_RREADY = (state==RUN) && FIFO not full. It is a combinational decode of registered state and count only, with no combinational path from AXI_RVALID.
- Accept: AXI_RVALID && AXI_RREADY.
  - Push {RDATA, last_flag} into the FIFO. last_flag = (beat_cnt==BURST_LEN-1).
  - beat_cnt increments. At BURST_LEN-1 it wraps to 0 and burst_cnt increments.
  - Framing is counter-based and ignores the RLAST value.
- Checks on each accepted beat (errors are sticky until a clear):
  - err_last sets if AXI_RLAST != last_flag.
  - err_resp sets if AXI_RRESP != 2'b00.
  - err_id sets if AXI_RID != EXP_ID.
- Error timing: each error flag asserts the edge after the offending beat is accepted.
- FIFO behaviour:
  - Show-ahead: m_valid = !empty, and m_data/m_last are the head entry.
  - Pop on m_valid && m_ready.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Full blocks the push through AXI_RREADY even if a pop occurs that cycle. The same-cycle pop frees space for the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Latency: an accepted beat appears on m_valid the next cycle when the FIFO was empty.
- burst_cnt saturates at NUM_BURSTS. No beats are accepted after the final beat.
- Beats arriving in IDLE, DRAIN or DONE are not accepted (AXI_RREADY=0).
- Async reset during a burst: immediate clear to IDLE. Any partially received beats are discarded.

Test Plan:
- Nominal sequence: init_done=1, m_ready=1, 5 bursts of 100 beats with RDATA=beat index, RLAST on beat 99, RRESP=0, RID=0.
  - Expect 500 beats out in order, with m_last on outputs 99, 199, 299, 399 and 499.
  - Expect burst_cnt=5 and rd_done=1 once the FIFO is empty, with no error flags.
- Backpressure: m_ready=0 with a continuous RVALID.
  - Expect exactly 16 beats accepted, then AXI_RREADY=0.
  - Raise m_ready for 1 cycle: one beat pops, and AXI_RREADY=1 on the following cycle. No data loss or duplication.
- Framing error: RLAST asserted on beat 50 of burst 0.
  - Expect err_last=1 the next cycle.
  - beat_cnt continues; burst 0 still ends on beat 99 with m_last=1 at that beat. err_last holds until init_done=0.
- Response and ID errors: beat 10 with RRESP=2'b10, beat 20 with RID=4'h3.
  - Expect err_resp=1 and err_id=1, both sticky. The data is still forwarded.
- Mid-operation clear: drop init_done for 1 cycle at burst 2, beat 40.
  - Expect FIFO empty, beat_cnt=0, burst_cnt=0 and errors 0 the next cycle.
  - Then a fresh 500-beat sequence completes normally.
- Async reset: assert sys_rst_n=0 between clock edges during RUN.
  - Expect AXI_RREADY, m_valid and rd_done to go to 0 immediately, before the next edge.
  - Expect state IDLE after release.

Source files
------------

// File: rtl/read_data_sink.sv
// HBM AXI read-data sink: buffers R-channel beats in a show-ahead FIFO, frames them
// into counted bursts, checks RLAST/RRESP/RID per beat and flags sequence completion.
module read_data_sink #(
    parameter int DATA_W     = 128,
    parameter int ID_W       = 4,
    parameter int BURST_LEN  = 100,
    parameter int NUM_BURSTS = 5,
    parameter int EXP_ID     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            sys_rst_n,
    input  logic                            init_done,
    input  logic [DATA_W-1:0]               AXI_RDATA,
    input  logic [ID_W-1:0]                 AXI_RID,
    input  logic                            AXI_RLAST,
    input  logic [1:0]                      AXI_RRESP,
    input  logic                            AXI_RVALID,
    output logic                            AXI_RREADY,
    output logic [DATA_W-1:0]               m_data,
    output logic                            m_last,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [$clog2(NUM_BURSTS+1)-1:0] burst_cnt,
    output logic [$clog2(BURST_LEN)-1:0]    beat_cnt,
    output logic                            err_last,
    output logic                            err_resp,
    output logic                            err_id,
    output logic                            rd_done
);

    localparam int BURST_W = $clog2(NUM_BURSTS+1);
    localparam int BEAT_W  = $clog2(BURST_LEN);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [1:0] IDLE_ST  = 2'b00;
    localparam logic [1:0] RUN_ST   = 2'b01;
    localparam logic [1:0] DRAIN_ST = 2'b10;
    localparam logic [1:0] DONE_ST  = 2'b11;

    localparam logic [BEAT_W-1:0]  BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0] BURST_FINAL = BURST_W'(NUM_BURSTS - 1);
    localparam logic [BURST_W-1:0] BURST_MAX   = BURST_W'(NUM_BURSTS);
    localparam logic [CNT_W-1:0]   CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [ID_W-1:0]    EXP_ID_V    = ID_W'(EXP_ID);
    localparam logic [1:0]         RESP_OKAY   = 2'b00;

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [DATA_W:0]    mem_r [FIFO_DEPTH];
    logic [DATA_W:0]    head_s;
    logic [BEAT_W-1:0]  beat_cnt_r;
    logic [BURST_W-1:0] burst_cnt_r;
    logic               err_last_r;
    logic               err_resp_r;
    logic               err_id_r;
    logic               rd_done_r;

    logic srst_s;
    logic full_s;
    logic empty_s;
    logic rready_s;
    logic acc_s;
    logic pop_s;
    logic last_flag_s;
    logic final_beat_s;

    // init_done low acts as the synchronous soft clear for the whole block
    assign srst_s       = !init_done;
    assign full_s       = (cnt_r == CNT_FULL);
    assign empty_s      = (cnt_r == {CNT_W{1'b0}});
    // Ready depends only on registered state and occupancy, never on RVALID
    assign rready_s     = (state_r == RUN_ST) && !full_s;
    assign acc_s        = AXI_RVALID && rready_s;
    assign pop_s        = !empty_s && m_ready;
    assign last_flag_s  = (beat_cnt_r == BEAT_LAST);
    assign final_beat_s = acc_s && last_flag_s && (burst_cnt_r == BURST_FINAL);
    assign head_s       = mem_r[rd_ptr_r];

    // Sequencing: IDLE -> RUN -> DRAIN -> DONE, soft clear returns to IDLE
    always_comb begin
        state_nxt_s = state_r;
        if (srst_s) begin
            state_nxt_s = IDLE_ST;
        end else begin
            case (state_r)
                IDLE_ST:  state_nxt_s = RUN_ST;
                RUN_ST:   state_nxt_s = final_beat_s ? DRAIN_ST : RUN_ST;
                DRAIN_ST: state_nxt_s = empty_s ? DONE_ST : DRAIN_ST;
                DONE_ST:  state_nxt_s = DONE_ST;
                default:  state_nxt_s = IDLE_ST;
            endcase
        end
    end

    // State register and registered completion flag
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= IDLE_ST;
            rd_done_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rd_done_r <= (state_nxt_s == DONE_ST);
        end
    end

    // FIFO pointers and occupancy; full blocks the push even if a pop frees space
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (srst_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({acc_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // FIFO storage: data plus the counter-derived last flag
    always_ff @(posedge clk) begin
        if (acc_s) begin
            mem_r[wr_ptr_r] <= {AXI_RDATA, last_flag_s};
        end
    end

    // Beat/burst framing counters, driven purely by accepted beat count
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beat_cnt_r  <= {BEAT_W{1'b0}};
            burst_cnt_r <= {BURST_W{1'b0}};
        end else if (srst_s) begin
            beat_cnt_r  <= {BEAT_W{1'b0}};
            burst_cnt_r <= {BURST_W{1'b0}};
        end else if (acc_s) begin
            if (last_flag_s) begin
                beat_cnt_r <= {BEAT_W{1'b0}};
                if (burst_cnt_r < BURST_MAX) begin
                    burst_cnt_r <= burst_cnt_r + BURST_W'(1);
                end
            end else begin
                beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
        end
    end

    // Sticky per-beat protocol checks
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_last_r <= 1'b0;
            err_resp_r <= 1'b0;
            err_id_r   <= 1'b0;
        end else if (srst_s) begin
            err_last_r <= 1'b0;
            err_resp_r <= 1'b0;
            err_id_r   <= 1'b0;
        end else if (acc_s) begin
            if (AXI_RLAST != last_flag_s) begin
                err_last_r <= 1'b1;
            end
            if (AXI_RRESP != RESP_OKAY) begin
                err_resp_r <= 1'b1;
            end
            if (AXI_RID != EXP_ID_V) begin
                err_id_r <= 1'b1;
            end
        end
    end

    assign AXI_RREADY = rready_s;
    assign m_valid    = !empty_s;
    // Head data is forced to zero while empty so stale entries never leak out
    assign m_data     = empty_s ? {DATA_W{1'b0}} : head_s[DATA_W:1];
    assign m_last     = empty_s ? 1'b0 : head_s[0];
    assign burst_cnt  = burst_cnt_r;
    assign beat_cnt   = beat_cnt_r;
    assign err_last   = err_last_r;
    assign err_resp   = err_resp_r;
    assign err_id     = err_id_r;
    assign rd_done    = rd_done_r;

endmodule

// File: tb/tb_read_data_sink.sv
// Randomized bench for read_data_sink, checked against a beat-queue reference model.
module tb_read_data_sink;

    localparam int DATA_W = 128;
    localparam int ID_W   = 4;
    localparam int BL     = 100;
    localparam int NB     = 5;
    localparam int DEPTH  = 16;
    localparam int TOTAL  = BL * NB;

    logic              clk = 1'b0;
    logic              sys_rst_n;
    logic              init_done;
    logic [DATA_W-1:0] AXI_RDATA;
    logic [ID_W-1:0]   AXI_RID;
    logic              AXI_RLAST;
    logic [1:0]        AXI_RRESP;
    logic              AXI_RVALID;
    logic              AXI_RREADY;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    logic [2:0]        burst_cnt;
    logic [6:0]        beat_cnt;
    logic              err_last;
    logic              err_resp;
    logic              err_id;
    logic              rd_done;

    always #5 clk = ~clk;

    read_data_sink #(
        .DATA_W(DATA_W), .ID_W(ID_W), .BURST_LEN(BL), .NUM_BURSTS(NB),
        .EXP_ID(0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
        .AXI_RDATA(AXI_RDATA), .AXI_RID(AXI_RID), .AXI_RLAST(AXI_RLAST),
        .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .burst_cnt(burst_cnt), .beat_cnt(beat_cnt), .err_last(err_last),
        .err_resp(err_resp), .err_id(err_id), .rd_done(rd_done)
    );

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } ent_t;

    // Reference model: queue of buffered beats plus count of beats taken so far
    ent_t q[$];
    int   total;
    bit   en, done_m, el, er, ei;

    int vectors, miscompares;
    int pv, pr, pclr, perr;
    bit nom;
    int inj_last, inj_resp, inj_id;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        total  = 0;
        en     = 1'b0;
        done_m = 1'b0;
        el     = 1'b0;
        er     = 1'b0;
        ei     = 1'b0;
    endtask

    task automatic check_all();
        bit rdy;
        rdy = en && (total < TOTAL) && (q.size() < DEPTH);
        check_eq("rready", AXI_RREADY, rdy);
        check_eq("m_valid", m_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("m_data", m_data, q[0].d);
            check_eq("m_last", m_last, q[0].l);
        end
        check_eq("burst_cnt", burst_cnt, total / BL);
        check_eq("beat_cnt", beat_cnt, total % BL);
        check_eq("err_last", err_last, el);
        check_eq("err_resp", err_resp, er);
        check_eq("err_id", err_id, ei);
        check_eq("rd_done", rd_done, done_m);
    endtask

    // Drive one cycle of stimulus from the negedge, advance the model, check at next negedge
    task automatic cycle(input bit force_clr);
        bit acc, pop, rdy, lflag;
        logic [DATA_W-1:0] d;
        ent_t e;
        init_done  = force_clr ? 1'b0 : !($urandom_range(0, 999) < pclr);
        AXI_RVALID = nom ? 1'b1 : ($urandom_range(0, 99) < pv);
        m_ready    = nom ? 1'b1 : ($urandom_range(0, 99) < pr);
        d = nom ? DATA_W'(total) : {$urandom(), $urandom(), $urandom(), $urandom()};
        lflag      = ((total % BL) == (BL - 1));
        AXI_RDATA  = d;
        AXI_RLAST  = lflag ^ ((total == inj_last) || ($urandom_range(0, 999) < perr));
        AXI_RRESP  = ((total == inj_resp) || ($urandom_range(0, 999) < perr))
                     ? 2'($urandom_range(1, 3)) : 2'b00;
        AXI_RID    = ((total == inj_id) || ($urandom_range(0, 999) < perr))
                     ? 4'($urandom_range(1, 15)) : 4'h0;
        rdy = en && (total < TOTAL) && (q.size() < DEPTH);
        acc = AXI_RVALID && rdy;
        pop = m_ready && (q.size() != 0);
        @(posedge clk);
        if (!init_done) begin
            model_reset();
        end else begin
            if ((total == TOTAL) && (q.size() == 0)) done_m = 1'b1;
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (AXI_RLAST != lflag) el = 1'b1;
                if (AXI_RRESP != 2'b00) er = 1'b1;
                if (AXI_RID != 4'h0) ei = 1'b1;
                e.d = d;
                e.l = lflag;
                q.push_back(e);
                total++;
            end
            en = 1'b1;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        sys_rst_n = 1'b0; init_done = 1'b0; m_ready = 1'b0;
        AXI_RDATA = '0; AXI_RID = '0; AXI_RLAST = 1'b0; AXI_RRESP = 2'b00; AXI_RVALID = 1'b0;
        inj_last = -1; inj_resp = -1; inj_id = -1;
        pv = 0; pr = 0; pclr = 0; perr = 0; nom = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        sys_rst_n = 1'b1;

        // Nominal 5 x 100 beat sequence
        nom = 1'b1;
        repeat (530) cycle(1'b0);
        check_eq("nom_done", rd_done, 1'b1);
        check_eq("nom_bursts", burst_cnt, 3'd5);
        check_eq("nom_errs", {err_last, err_resp, err_id}, 3'b000);

        // Backpressure, with framing/response/ID errors injected later in the sequence
        inj_last = 50; inj_resp = 10; inj_id = 20;
        cycle(1'b1);
        nom = 1'b0; pv = 100; pr = 0;
        repeat (25) cycle(1'b0);
        check_eq("bp_full_rready", AXI_RREADY, 1'b0);
        check_eq("bp_accepted", beat_cnt, 7'd16);
        pr = 100;
        cycle(1'b0);
        pr = 0;
        check_eq("bp_pop_rready", AXI_RREADY, 1'b1);
        cycle(1'b0);
        check_eq("bp_refill_rready", AXI_RREADY, 1'b0);
        pv = 60; pr = 70;
        repeat (1500) cycle(1'b0);
        check_eq("inj_err_last", err_last, 1'b1);
        check_eq("inj_err_resp", err_resp, 1'b1);
        check_eq("inj_err_id", err_id, 1'b1);

        // Mid-operation clear at burst 2 beat 40, then a fresh sequence
        inj_last = -1; inj_resp = -1; inj_id = -1;
        cycle(1'b1);
        nom = 1'b1;
        for (int i = 0; i < 400 && total < 240; i++) cycle(1'b0);
        check_eq("clr_at_burst", burst_cnt, 3'd2);
        check_eq("clr_at_beat", beat_cnt, 7'd40);
        cycle(1'b1);
        check_eq("clr_beat", beat_cnt, 7'd0);
        check_eq("clr_burst", burst_cnt, 3'd0);
        check_eq("clr_valid", m_valid, 1'b0);
        repeat (530) cycle(1'b0);
        check_eq("clr_then_done", rd_done, 1'b1);

        // Random stress with occasional clears and protocol errors
        nom = 1'b0; pv = 70; pr = 60; pclr = 1; perr = 5;
        repeat (3000) cycle(1'b0);

        // Asynchronous reset while running with data buffered
        pclr = 0; perr = 0;
        cycle(1'b1);
        pv = 100; pr = 0;
        repeat (6) cycle(1'b0);
        #2 sys_rst_n = 1'b0;
        #1;
        check_eq("arst_rready", AXI_RREADY, 1'b0);
        check_eq("arst_mvalid", m_valid, 1'b0);
        check_eq("arst_done", rd_done, 1'b0);
        model_reset();
        @(negedge clk);
        sys_rst_n = 1'b1;
        check_all();

        // Asynchronous reset from the completed state
        nom = 1'b1;
        repeat (530) cycle(1'b0);
        check_eq("done_pre_arst", rd_done, 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        check_eq("arst_done_clr", rd_done, 1'b0);
        model_reset();
        @(negedge clk);
        sys_rst_n = 1'b1;
        check_all();
        cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
